// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM state encoding,
// instruction class opcodes, ALU operation codes and fault codes.
package core_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StFault
    } state_e;

    typedef enum logic [1:0] {
        ClsMovz,
        ClsAddi,
        ClsSubi,
        ClsUndef
    } op_class_e;

    // Instruction class is selected by ir[31:23]
    localparam logic [8:0] OP_MOVZ = 9'b110100101;
    localparam logic [8:0] OP_ADDI = 9'b100100010;
    localparam logic [8:0] OP_SUBI = 9'b110100010;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_NONE = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_UNDEF   = 2'b10;

endpackage

// File: rtl/core_op_classify.sv
// Combinational opcode classifier: ir[31:23] -> instruction class, ALU op and
// whether register 31 names SP (ADDI/SUBI) rather than XZR (MOVZ).
module core_op_classify
    import core_seq_ctrl_pkg::*;
(
    input  logic [8:0] opc,
    output logic [1:0] op_class,
    output logic [1:0] alu_op,
    output logic       sp_sel
);

    // Decode the opcode field; anything unrecognised is UNDEF
    always_comb begin
        op_class = ClsUndef;
        alu_op   = ALU_NONE;
        sp_sel   = 1'b0;
        case (opc)
            OP_MOVZ: begin
                op_class = ClsMovz;
                alu_op   = ALU_PASS;
            end
            OP_ADDI: begin
                op_class = ClsAddi;
                alu_op   = ALU_ADD;
                sp_sel   = 1'b1;
            end
            OP_SUBI: begin
                op_class = ClsSubi;
                alu_op   = ALU_SUB;
                sp_sel   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the ARM64 subset core.
// Optional build macro UNDEF_TRAP_EN: when defined, an undefined opcode in
// DECODE enters FAULT (code 10) with pc held; otherwise it retires as a NOP.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir_out,
    output logic [1:0]  alu_op,
    output logic [4:0]  rf_raddr,
    output logic [4:0]  rf_waddr,
    output logic        sp_sel,
    output logic        rf_we,
    output logic [63:0] pc,
    output logic [31:0] instret,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    // Last FETCH cycle index; no ack by then means timeout
    localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [15:0] tmo_q, tmo_d;

    logic [1:0]  cls;
    logic [1:0]  cls_alu_op;
    logic        cls_sp_sel;

    core_op_classify u_classify (
        .opc      (ir_q[31:23]),
        .op_class (cls),
        .alu_op   (cls_alu_op),
        .sp_sel   (cls_sp_sel)
    );

    // State and architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            instret_q    <= '0;
            fault_code_q <= FAULT_NONE;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            instret_q    <= instret_d;
            fault_code_q <= fault_code_d;
            tmo_q        <= tmo_d;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        instret_d    = instret_q;
        fault_code_d = fault_code_q;
        tmo_d        = tmo_q;
        imem_req     = 1'b0;
        rf_we        = 1'b0;
        alu_op       = ALU_NONE;
        sp_sel       = 1'b0;
        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (run) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                // Ack wins over an expiring timeout in the same cycle
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    tmo_d   = '0;
                    state_d = StDecode;
                end else if (tmo_q == TMO_LAST) begin
                    fault_code_d = FAULT_TIMEOUT;
                    state_d      = StFault;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StDecode: begin
                sp_sel = cls_sp_sel;
                if (!stall) begin
`ifdef UNDEF_TRAP_EN
                    if (cls == ClsUndef) begin
                        fault_code_d = FAULT_UNDEF;
                        state_d      = StFault;
                    end else begin
                        state_d = StExec;
                    end
`else
                    state_d = StExec;
`endif
                end
            end
            StExec: begin
                alu_op = cls_alu_op;
                sp_sel = cls_sp_sel;
                if (!stall) state_d = StWb;
            end
            StWb: begin
                alu_op = cls_alu_op;
                sp_sel = cls_sp_sel;
                // MOVZ to register 31 targets XZR, so the write is discarded
                rf_we     = (cls != ClsUndef) && !(cls == ClsMovz && ir_q[4:0] == 5'd31);
                pc_d      = pc_q + 64'd4;
                instret_d = instret_q + 32'd1;
                state_d   = run ? StFetch : StIdle;
            end
            StFault: ;
            default: state_d = StIdle;
        endcase
    end

    assign imem_addr  = pc_q;
    assign ir_out     = ir_q;
    assign rf_raddr   = ir_q[9:5];
    assign rf_waddr   = ir_q[4:0];
    assign pc         = pc_q;
    assign instret    = instret_q;
    assign busy       = (state_q != StIdle) && (state_q != StFault);
    assign fault      = (state_q == StFault);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: directed steps plus randomized
// instructions checked against a transaction-level model of pc/instret/decode.
module tb_core_seq_ctrl;

    localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam int unsigned TMO = 12;

    logic        clk = 1'b0;
    logic        rst, run, stall;
    logic        imem_req, imem_ack;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic [1:0]  alu_op;
    logic [4:0]  rf_raddr, rf_waddr;
    logic        sp_sel, rf_we;
    logic [63:0] pc;
    logic [31:0] instret;
    logic        busy, fault;
    logic [1:0]  fault_code;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] m_pc;
    logic [31:0] m_instret;

    core_seq_ctrl #(
        .RESET_PC      (RPC),
        .FETCH_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .alu_op     (alu_op),
        .rf_raddr   (rf_raddr),
        .rf_waddr   (rf_waddr),
        .sp_sel     (sp_sel),
        .rf_we      (rf_we),
        .pc         (pc),
        .instret    (instret),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one instruction word
    task automatic ref_decode(input logic [31:0] w, output logic [1:0] aop, output logic sp,
                              output logic we);
        logic [8:0] opc;
        opc = w[31:23];
        if (opc == 9'b110100101) begin
            aop = 2'd0; sp = 1'b0; we = (w[4:0] != 5'd31);
        end else if (opc == 9'b100100010) begin
            aop = 2'd1; sp = 1'b1; we = 1'b1;
        end else if (opc == 9'b110100010) begin
            aop = 2'd2; sp = 1'b1; we = 1'b1;
        end else begin
            aop = 2'd3; sp = 1'b0; we = 1'b0;
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {63'd0, imem_req}, 64'd1);
    endtask

    // One instruction: d fetch wait cycles, ds/es stall cycles in DECODE/EXEC
    task automatic do_instr(input logic [31:0] w, input int d, input int ds, input int es,
                            input bit drop_run);
        logic [1:0] aop;
        logic       sp, we;
        ref_decode(w, aop, sp, we);
        wait_fetch();
        chk("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < d; i++) begin
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fetch_req_held", {63'd0, imem_req}, 64'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("ir_out", {32'd0, ir_out}, {32'd0, w});
        chk("dec_raddr", {59'd0, rf_raddr}, {59'd0, w[9:5]});
        chk("dec_sp_sel", {63'd0, sp_sel}, {63'd0, sp});
        chk("dec_alu_op", {62'd0, alu_op}, 64'd3);
        chk("dec_req", {63'd0, imem_req}, 64'd0);
        if (drop_run) run = 1'b0;
        stall = (ds > 0);
        for (int i = 1; i <= ds; i++) begin
            @(negedge clk);
            chk("dec_hold_alu_op", {62'd0, alu_op}, 64'd3);
            chk("dec_hold_we", {63'd0, rf_we}, 64'd0);
            stall = (i < ds);
        end
        @(negedge clk);
        chk("exec_alu_op", {62'd0, alu_op}, {62'd0, aop});
        chk("exec_we", {63'd0, rf_we}, 64'd0);
        chk("exec_pc", pc, m_pc);
        stall = (es > 0);
        for (int i = 1; i <= es; i++) begin
            @(negedge clk);
            chk("exec_hold_we", {63'd0, rf_we}, 64'd0);
            chk("exec_hold_pc", pc, m_pc);
            stall = (i < es);
        end
        @(negedge clk);
        chk("wb_we", {63'd0, rf_we}, {63'd0, we});
        chk("wb_waddr", {59'd0, rf_waddr}, {59'd0, w[4:0]});
        chk("wb_alu_op", {62'd0, alu_op}, {62'd0, aop});
        chk("wb_pc_old", pc, m_pc);
        stall = 1'($urandom_range(0, 1));
        m_pc      = m_pc + 64'd4;
        m_instret = m_instret + 32'd1;
        @(negedge clk);
        stall = 1'b0;
        chk("pc_next", pc, m_pc);
        chk("instret", {32'd0, instret}, {32'd0, m_instret});
        chk("post_we", {63'd0, rf_we}, 64'd0);
        chk("post_req", {63'd0, imem_req}, {63'd0, run});
        chk("post_busy", {63'd0, busy}, {63'd0, run});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        m_pc      = RPC;
        m_instret = '0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; run = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_ir", {32'd0, ir_out}, 64'd0);
        chk("rst_instret", {32'd0, instret}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_fault", {63'd0, fault}, 64'd0);
        chk("rst_fault_code", {62'd0, fault_code}, 64'd0);
        chk("rst_alu_op", {62'd0, alu_op}, 64'd3);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        rst = 1'b0;
        m_pc = RPC;
        m_instret = '0;
        @(negedge clk);
        chk("idle_no_req", {63'd0, imem_req}, 64'd0);
        run = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch", {63'd0, imem_req}, 64'd1);

        // Directed instructions; pc wraps through 2^64 on the fourth one
        do_instr(32'hD2800541, 0, 0, 0, 1'b0);
        do_instr(32'h910043FF, 0, 0, 0, 1'b0);
        do_instr(32'hD1000462, 0, 0, 0, 1'b0);
        do_instr(32'hD280001F, 0, 0, 0, 1'b0);
        chk("pc_wrapped", m_pc, 64'h0);

        // Undefined opcode
`ifdef UNDEF_TRAP_EN
        wait_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("undef_fault", {63'd0, fault}, 64'd1);
        chk("undef_code", {62'd0, fault_code}, 64'd2);
        chk("undef_pc", pc, m_pc);
        chk("undef_busy", {63'd0, busy}, 64'd0);
        do_reset();
        run = 1'b1;
`else
        do_instr(32'h00000000, 0, 0, 0, 1'b0);
`endif

        // Stalls in DECODE and EXEC
        do_instr(32'hD2800541, 1, 3, 3, 1'b0);
        // run dropped mid-instruction: completes, then IDLE
        do_instr(32'h910043FF, 2, 1, 0, 1'b1);
        @(negedge clk);
        chk("idle_stays", {63'd0, imem_req}, 64'd0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_fetch", {63'd0, imem_req}, 64'd1);

        // Randomized instruction mix
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0: w = {9'b110100101, 2'($urandom), 16'($urandom), 5'($urandom)};
                1: w = {9'b100100010, 23'($urandom)};
                2: w = {9'b110100010, 23'($urandom)};
`ifdef UNDEF_TRAP_EN
                default: w = {9'b100100010, 23'($urandom)};
`else
                default: w = $urandom;
`endif
            endcase
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                     1'b0);
        end

        // Ack on the expiry cycle wins
        do_instr(32'hD1000462, int'(TMO) - 1, 0, 0, 1'b0);

        // Fetch timeout
        wait_fetch();
        for (int i = 1; i <= int'(TMO); i++) begin
            chk("tmo_req", {63'd0, imem_req}, 64'd1);
            @(negedge clk);
        end
        chk("tmo_fault", {63'd0, fault}, 64'd1);
        chk("tmo_code", {62'd0, fault_code}, 64'd1);
        chk("tmo_req_drop", {63'd0, imem_req}, 64'd0);
        chk("tmo_busy", {63'd0, busy}, 64'd0);
        chk("tmo_pc", pc, m_pc);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            imem_ack = 1'b0;
            chk("fault_sticky", {63'd0, fault}, 64'd1);
            chk("fault_pc_frozen", pc, m_pc);
            chk("fault_no_we", {63'd0, rf_we}, 64'd0);
        end
        chk("fault_instret", {32'd0, instret}, {32'd0, m_instret});

        // Reset mid-fetch
        do_reset();
        run = 1'b1;
        @(negedge clk);
        do_instr(32'hD2800541, 0, 0, 0, 1'b0);
        chk("pre_rst_req", {63'd0, imem_req}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_req_drop", {63'd0, imem_req}, 64'd0);
        chk("rst_pc_async", pc, RPC);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hD2800541;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_ir", {32'd0, ir_out}, 64'd0);
        chk("late_ack_busy", {63'd0, busy}, 64'd0);
        chk("late_ack_instret", {32'd0, instret}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
